// File: rtl/rs_syndrome_calc_p.sv
// rs_syndrome_calc_p
// Streaming syndrome calculator for the RS(544,522), t=11 decoder over GF(2^10).
// It takes P symbols per beat, highest degree first, and Horner-accumulates the
// 2T syndromes s_j = r(alpha^j). A closed frame is loaded into a single-entry
// output register that presents s1..s2T on a bus shaped like the solver's syn_i,
// with index 0 hard-wired to zero.
//
// Optional feature (macro SYNCALC_ERRFREE_EN): when defined, a frame whose 2T
// syndromes are all zero and whose framing is good is not presented.
// err_free_o pulses for one cycle instead. When undefined, err_free_o is tied
// to 0 and every closed frame is presented.
//
// Ports:
//   clk_i        clock
//   rst_ni       synchronous active-low reset
//   sym_i[0:P-1] input symbols; lane 0 holds the highest degree of the beat
//   in_valid_i   input beat valid
//   in_last_i    final beat of a frame
//   in_ready_o   block can accept a beat
//   syn_o[0:2T]  syn_o[0]=0, syn_o[j]=s_j for j=1..2T
//   syn_valid_o  output register holds a result
//   syn_ready_i  consumer takes the held result
//   len_err_o    framing error flag of the held result
//   err_free_o   all 2T syndromes of the closed frame are zero
module rs_syndrome_calc_p #(
    parameter int T = 11,
    parameter int W = 10,
    parameter int N = 544,
    parameter int P = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] sym_i [0:P-1],
    input  logic         in_valid_i,
    input  logic         in_last_i,
    output logic         in_ready_o,
    output logic [W-1:0] syn_o [0:2*T],
    output logic         syn_valid_o,
    input  logic         syn_ready_i,
    output logic         len_err_o,
    output logic         err_free_o
);

    localparam int BEATS = N / P;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);
    // Low-order taps of the field polynomial x^10 + x^3 + 1.
    localparam logic [W-1:0] POLY_LOW = W'(10'h009);

    if (N % P != 0) begin : g_bad_p
        $fatal(1, "rs_syndrome_calc_p: N must be a multiple of P");
    end

    // Multiply by alpha (= x) with reduction.
    function automatic logic [W-1:0] xtime(input logic [W-1:0] x);
        return {x[W-2:0], 1'b0} ^ (x[W-1] ? POLY_LOW : '0);
    endfunction

    // alpha^e, evaluated at elaboration for constant exponents.
    function automatic logic [W-1:0] alpha_pow(input int e);
        logic [W-1:0] x;
        x = W'(1);
        for (int i = 0; i < e; i++) x = xtime(x);
        return x;
    endfunction

    // Constant multiplier. With c constant, every output bit reduces to an XOR
    // of input bits: column i of the matrix is c*alpha^i.
    function automatic logic [W-1:0] mul_const(input logic [W-1:0] x,
                                               input logic [W-1:0] c);
        logic [W-1:0] r;
        logic [W-1:0] col;
        r   = '0;
        col = c;
        for (int i = 0; i < W; i++) begin
            r   = r ^ (col & {W{x[i]}});
            col = xtime(col);
        end
        return r;
    endfunction

    logic [CW-1:0] beat_cnt_p0;
    logic [W-1:0]  acc_p0   [1:2*T];
    logic [W-1:0]  acc_next [1:2*T];
    logic [W-1:0]  syn_p1   [1:2*T];
    logic          syn_vld_p1;
    logic          len_err_p1;

    logic first_beat;
    logic closing;
    logic accept;
    logic close;
    logic len_err_new;

    // A frame may close early on in_last_i, or on the count.
    assign first_beat  = (beat_cnt_p0 == '0);
    assign closing     = (beat_cnt_p0 == LAST_CNT) || in_last_i;
    // Only a closing beat needs the output register. Other beats keep
    // flowing while a result is held.
    assign in_ready_o  = !(syn_vld_p1 && !syn_ready_i && closing);
    assign accept      = in_valid_i && in_ready_o;
    assign close       = accept && closing;
    assign len_err_new = (beat_cnt_p0 == LAST_CNT) != in_last_i;

    // Stage p0: Horner update. On the first beat of a frame the accumulator
    // is taken as zero, so no separate clear cycle is needed.
    for (genvar j = 1; j <= 2*T; j++) begin : g_syn
        localparam logic [W-1:0] STEP = alpha_pow(j * P);
        logic [W-1:0] sum;
        always_comb begin
            sum = mul_const(first_beat ? '0 : acc_p0[j], STEP);
            for (int l = 0; l < P; l++) begin
                sum = sum ^ mul_const(sym_i[l], alpha_pow(j * (P - 1 - l)));
            end
        end
        assign acc_next[j] = sum;
        assign syn_o[j]    = syn_p1[j];
    end
    assign syn_o[0] = '0;

`ifdef SYNCALC_ERRFREE_EN
    logic all_zero;
    logic err_free_p1;
    always_comb begin
        all_zero = 1'b1;
        for (int j = 1; j <= 2*T; j++) begin
            if (acc_next[j] != '0) all_zero = 1'b0;
        end
    end
    assign err_free_o = err_free_p1;
`else
    assign err_free_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            beat_cnt_p0 <= '0;
            for (int j = 1; j <= 2*T; j++) begin
                acc_p0[j] <= '0;
                syn_p1[j] <= '0;
            end
            syn_vld_p1 <= 1'b0;
            len_err_p1 <= 1'b0;
`ifdef SYNCALC_ERRFREE_EN
            err_free_p1 <= 1'b0;
`endif
        end else begin
            if (accept) begin
                acc_p0      <= acc_next;
                beat_cnt_p0 <= closing ? '0 : beat_cnt_p0 + CW'(1);
            end
            // Stage p1: output register. A close takes priority over a pop,
            // so a pop and a close in the same cycle leave valid set.
            if (close) begin
                syn_p1     <= acc_next;
                len_err_p1 <= len_err_new;
`ifdef SYNCALC_ERRFREE_EN
                err_free_p1 <= all_zero;
                syn_vld_p1  <= !(all_zero && !len_err_new);
`else
                syn_vld_p1 <= 1'b1;
`endif
            end else begin
                if (syn_vld_p1 && syn_ready_i) syn_vld_p1 <= 1'b0;
`ifdef SYNCALC_ERRFREE_EN
                // A flag belonging to a dropped frame lives for one cycle only.
                // A flag belonging to a presented frame lives until it is popped.
                err_free_p1 <= err_free_p1 && syn_vld_p1 && !syn_ready_i;
`endif
            end
        end
    end

    assign syn_valid_o = syn_vld_p1;
    assign len_err_o   = len_err_p1;

endmodule

// File: tb/tb_rs_syndrome_calc_p.sv
// Testbench for rs_syndrome_calc_p. It uses a table of directed frames and
// checks each result against a direct-sum GF(2^10) reference model. It also
// runs hand-written sequences for backpressure and for a reset in mid-frame.
module tb_rs_syndrome_calc_p;

    localparam int T     = 11;
    localparam int W     = 10;
    localparam int N     = 544;
    localparam int P     = 4;
    localparam int BEATS = N / P;
    localparam int NS    = 2 * T;
`ifdef SYNCALC_ERRFREE_EN
    localparam bit EF = 1'b1;
`else
    localparam bit EF = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] sym [0:P-1];
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [W-1:0] syn [0:2*T];
    logic         syn_valid;
    logic         syn_ready;
    logic         len_err;
    logic         err_free;

    always #5 clk = ~clk;

    rs_syndrome_calc_p #(.T(T), .W(W), .N(N), .P(P)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .sym_i      (sym),
        .in_valid_i (in_valid),
        .in_last_i  (in_last),
        .in_ready_o (in_ready),
        .syn_o      (syn),
        .syn_valid_o(syn_valid),
        .syn_ready_i(syn_ready),
        .len_err_o  (len_err),
        .err_free_o (err_free)
    );

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] seq [0:N-1];   // symbols in send order (seq[0] = r543)
    logic [W-1:0] exp_syn [1:NS];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_syn(input string name);
        bit bad;
        bad = 1'b0;
        checks++;
        for (int j = 1; j <= NS; j++) begin
            if (!bad && syn[j] !== exp_syn[j]) begin
                bad = 1'b1;
                $display("FAIL %s: s%0d got 0x%0h expected 0x%0h", name, j, syn[j], exp_syn[j]);
            end
        end
        if (syn[0] !== '0 && !bad) begin
            bad = 1'b1;
            $display("FAIL %s: s0 got 0x%0h expected 0x0", name, syn[0]);
        end
        if (bad) failures++;
    endtask

    function automatic logic [W-1:0] gf_mul(input logic [W-1:0] a_in, input logic [W-1:0] b);
        logic [W-1:0] a;
        logic [W-1:0] r;
        a = a_in;
        r = '0;
        for (int i = 0; i < W; i++) begin
            if (b[i]) r ^= a;
            a = a[W-1] ? ({a[W-2:0], 1'b0} ^ 10'h009) : {a[W-2:0], 1'b0};
        end
        return r;
    endfunction

    // Reference model: s_j = sum over m of seq[m] * alpha^(j*(M-1-m)).
    // The last symbol sent is degree 0.
    task automatic model(input int m_len);
        logic [W-1:0] aj;
        logic [W-1:0] pw;
        logic [W-1:0] s;
        for (int j = 1; j <= NS; j++) begin
            aj = 10'h001;
            for (int k = 0; k < j; k++) aj = gf_mul(aj, 10'h002);
            pw = 10'h001;
            s  = '0;
            for (int m = m_len - 1; m >= 0; m--) begin
                s  ^= gf_mul(seq[m], pw);
                pw  = gf_mul(pw, aj);
            end
            exp_syn[j] = s;
        end
    endtask

    // seed != 0: pseudo-random frame. Otherwise all zero, with an optional
    // single symbol val placed at degree pos.
    task automatic fill_frame(input int pos, input logic [W-1:0] val, input int seed);
        logic [31:0] st;
        st = seed;
        for (int k = 0; k < N; k++) begin
            st     = st * 32'd1664525 + 32'd1013904223;
            seq[k] = (seed != 0) ? st[25:16] : '0;
        end
        if (seed == 0 && pos >= 0) seq[N - 1 - pos] = val;
    endtask

    task automatic drive_beat(input int b, input bit last);
        @(negedge clk);
        for (int l = 0; l < P; l++) sym[l] = seq[b * P + l];
        in_valid = 1'b1;
        in_last  = last;
        #1;
    endtask

    task automatic send_range(input int b0, input int b1, input int last_flag_beat);
        for (int b = b0; b <= b1; b++) begin
            drive_beat(b, b == last_flag_beat);
            check($sformatf("in_ready_beat%0d", b), in_ready, 1'b1);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        #1;
    endtask

    task automatic pop(input string name);
        @(negedge clk);
        syn_ready = 1'b1;
        @(negedge clk);
        syn_ready = 1'b0;
        #1;
        check({name, "_popped"}, syn_valid, 1'b0);
    endtask

    typedef struct {
        int           pos;
        logic [W-1:0] val;
        int           seed;
        int           last_beat;   // -1: in_last_i never raised
        bit           exp_len_err;
        bit           hand;
        logic [W-1:0] hs1;
        logic [W-1:0] hs10;
    } vec_t;

    vec_t vecs [0:8];

    initial begin
        bit all_zero;
        bit exp_drop;
        int close_beat;

        vecs[0] = '{-1,  10'h000, 0,  135, 1'b0, 1'b1, 10'h000, 10'h000};
        vecs[1] = '{0,   10'h001, 0,  135, 1'b0, 1'b1, 10'h001, 10'h001};
        vecs[2] = '{1,   10'h001, 0,  135, 1'b0, 1'b1, 10'h002, 10'h009};
        vecs[3] = '{2,   10'h001, 0,  135, 1'b0, 1'b1, 10'h004, 10'h041};
        vecs[4] = '{-1,  10'h000, 11, 135, 1'b0, 1'b0, 10'h000, 10'h000};
        vecs[5] = '{-1,  10'h000, 12, -1,  1'b1, 1'b0, 10'h000, 10'h000};
        vecs[6] = '{-1,  10'h000, 13, 100, 1'b1, 1'b0, 10'h000, 10'h000};
        vecs[7] = '{-1,  10'h000, 14, 135, 1'b0, 1'b0, 10'h000, 10'h000};
        vecs[8] = '{543, 10'h3FF, 0,  135, 1'b0, 1'b0, 10'h000, 10'h000};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        syn_ready = 1'b0;
        for (int l = 0; l < P; l++) sym[l] = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int j = 1; j <= NS; j++) exp_syn[j] = '0;
        check("rst_syn_valid", syn_valid, 1'b0);
        check("rst_len_err", len_err, 1'b0);
        check("rst_err_free", err_free, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check_syn("rst_syn");

        // Table of directed frames.
        for (int i = 0; i < 9; i++) begin
            close_beat = (vecs[i].last_beat >= 0) ? vecs[i].last_beat : BEATS - 1;
            fill_frame(vecs[i].pos, vecs[i].val, vecs[i].seed);
            model((close_beat + 1) * P);
            all_zero = 1'b1;
            for (int j = 1; j <= NS; j++) if (exp_syn[j] != '0) all_zero = 1'b0;
            exp_drop = EF && all_zero && !vecs[i].exp_len_err;
            send_range(0, close_beat, vecs[i].last_beat);
            idle();
            check($sformatf("v%0d_syn_valid", i), syn_valid, !exp_drop);
            check($sformatf("v%0d_err_free", i), err_free, EF && all_zero);
            if (exp_drop) begin
                @(negedge clk);
                #1;
                check($sformatf("v%0d_err_free_pulse_end", i), err_free, 1'b0);
                check($sformatf("v%0d_dropped", i), syn_valid, 1'b0);
            end else begin
                check($sformatf("v%0d_len_err", i), len_err, vecs[i].exp_len_err);
                check_syn($sformatf("v%0d_syn", i));
                if (vecs[i].hand) begin
                    check($sformatf("v%0d_hand_s1", i), syn[1], vecs[i].hs1);
                    check($sformatf("v%0d_hand_s10", i), syn[10], vecs[i].hs10);
                end
                pop($sformatf("v%0d", i));
            end
        end

        // Back-to-back frames with the first result held.
        fill_frame(-1, '0, 31);
        model(N);
        send_range(0, BEATS - 1, BEATS - 1);
        idle();
        check("b2b_a_valid", syn_valid, 1'b1);
        check_syn("b2b_a_syn");
        fill_frame(-1, '0, 32);
        send_range(0, BEATS - 2, -1);
        drive_beat(BEATS - 1, 1'b1);
        check("b2b_stall_ready", in_ready, 1'b0);
        @(negedge clk);
        #1;
        check("b2b_stall_ready_hold", in_ready, 1'b0);
        check("b2b_a_still_valid", syn_valid, 1'b1);
        check_syn("b2b_a_held_syn");
        syn_ready = 1'b1;
        #1;
        check("b2b_release_ready", in_ready, 1'b1);
        @(negedge clk);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        syn_ready = 1'b0;
        #1;
        model(N);
        check("b2b_b_valid", syn_valid, 1'b1);
        check("b2b_b_len_err", len_err, 1'b0);
        check_syn("b2b_b_syn");
        pop("b2b_b");

        // Reset in mid-frame while a result is held.
        fill_frame(-1, '0, 41);
        send_range(0, BEATS - 1, BEATS - 1);
        idle();
        check("mrst_pre_valid", syn_valid, 1'b1);
        fill_frame(-1, '0, 42);
        send_range(0, 69, -1);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int j = 1; j <= NS; j++) exp_syn[j] = '0;
        check("mrst_syn_valid", syn_valid, 1'b0);
        check("mrst_len_err", len_err, 1'b0);
        check("mrst_in_ready", in_ready, 1'b1);
        check_syn("mrst_syn_zero");
        fill_frame(-1, '0, 43);
        model(N);
        send_range(0, BEATS - 1, BEATS - 1);
        idle();
        check("mrst_after_valid", syn_valid, 1'b1);
        check("mrst_after_len_err", len_err, 1'b0);
        check_syn("mrst_after_syn");
        pop("mrst_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rs_syndrome_calc_p.md
Name: rs_syndrome_calc_p

Overview:
- Streaming syndrome calculator for the RS(544,522), t=11 decoder over GF(2^10). Sits directly upstream of ribm_solver_3t.
- Consumes one received codeword as P symbols per beat, highest-degree symbol first (r543 down to r0).
- Produces s1..s22 on a bus shaped exactly like the solver's syn_i, with index 0 tied to 0, behind a single-entry valid/ready output register.

Parameters:
- T, 11: error-correction capability; 2T syndromes are computed.
- W, 10: symbol width. Field polynomial x^10+x^3+1, alpha = 0x002.
- N, 544: codeword length in symbols.
- P, 4: symbols per input beat. N mod P must be 0; otherwise the block raises an elaboration $fatal.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; synchronous, active-low.
- sym_i[0:P-1]  in  W each  input symbols; lane 0 carries the highest degree of the beat.
- in_valid_i  in  1  input beat valid.
- in_last_i  in  1  marks the final beat of a frame.
- in_ready_o  out  1  block can accept a beat.
- syn_o[0:2T]  out  W each  syn_o[0]=0; syn_o[j]=s_j=r(alpha^j) for j=1..2T.
- syn_valid_o  out  1  syndrome register holds a result.
- syn_ready_i  in  1  consumer accepts the result; the solver drives this with !busy_o.
- len_err_o  out  1  framing error flag for the held result; valid while syn_valid_o=1.
- err_free_o  out  1  all 2T syndromes are zero; valid while syn_valid_o=1. See Optional Feature.

Behaviour:
- Reset (rst_ni=0 at a clock edge):
  - acc[1..2T]=0, beat_cnt=0, output register and syn_o all 0.
  - syn_valid_o=0, len_err_o=0, err_free_o=0.
  - Reset mid-frame discards the partial frame and any held result.
  - in_ready_o=1 in the first cycle after reset.
- Accept rule: a beat transfers when in_valid_i && in_ready_o.
- Per accepted beat, for each j=1..2T (Horner update):
  - acc_j <= acc_j * alpha^(jP) XOR sum over l=0..P-1 of sym_i[l] * alpha^(j(P-1-l)).
  - All multipliers are by constants; build them as XOR matrices generated at elaboration.
  - On the first beat of a frame, acc is treated as 0 (no separate clear cycle).
- beat_cnt counts 0..N/P-1. A frame closes on the beat where beat_cnt==N/P-1 or in_last_i=1, whichever comes first.
- On close:
  - The updated acc values are loaded into the output register.
  - syn_valid_o=1 from the next cycle.
  - beat_cnt resets to 0; the next accepted beat starts a new frame.
  - Close latency: 1 cycle after the final beat.
- len_err_o is set for the closed frame if either:
  - in_last_i=1 arrived with beat_cnt!=N/P-1 (early close), or
  - beat_cnt==N/P-1 arrived with in_last_i=0 (closed by count).
- Output handshake:
  - The output register clears syn_valid_o on syn_valid_o && syn_ready_i.
  - syn_o holds its value until reloaded.
- Backpressure:
  - in_ready_o = !(syn_valid_o && !syn_ready_i && closing_beat).
  - closing_beat means beat_cnt==N/P-1 or in_last_i=1.
  - Non-closing beats are always accepted, so the next frame accumulates while a result is held.
- Simultaneous pop and close in the same cycle: the new result loads and syn_valid_o stays 1.
- No internal state machine beyond beat_cnt plus the output-register full bit; the frame state is implicit in beat_cnt (0 means idle or first beat).
- Bus shape matches the solver: syn_o[0] is hard 0 and never registered non-zero.

Optional Feature:
- Macro: SYNCALC_ERRFREE_EN.
- When defined:
  - err_free_o is registered on close as NOR of all 2T new syndromes.
  - When a frame closes with err_free_o=1 and len_err_o=0, syn_valid_o stays 0 and the result is dropped; the solver is never started for error-free codewords.
  - err_free_o pulses high for 1 cycle in that case.
- When not defined:
  - err_free_o is tied 0.
  - Every closed frame is presented on syn_valid_o.

Test Plan:
- All-zero codeword, 136 beats, last on beat 135:
  - Without the macro: syn_valid_o=1 one cycle later with syn_o[1..22]=0x000 and len_err_o=0.
  - With SYNCALC_ERRFREE_EN: err_free_o pulses and syn_valid_o stays 0.
- r0=0x001, all other symbols 0: every s_j=0x001, j=1..22.
- r1=0x001, all other symbols 0: s1=0x002, s2=0x004, s9=0x200, s10=0x009; s_j=alpha^j in general. Check against a software GF model.
- Back-to-back frames with syn_ready_i held 0:
  - Frame 1 is held.
  - Frame 2 beats 0..134 are accepted; in_ready_o=0 on beat 135.
  - Raising syn_ready_i pops frame 1 and accepts beat 135 in the same cycle; frame 2 syndromes appear next cycle.
- in_last_i on beat 100: frame closes with len_err_o=1, and the next beat starts a fresh frame with correct syndromes.
- rst_ni low at beat 70: all outputs go to 0; a full frame sent afterwards yields reference-correct syndromes.
